avr_serial_tx: RTL

UART transmitter from the FPGA to the AVR: the FPGA drives avr_rx, the AVR consumes it. Buffers bytes from internal logic in a small FIFO, serialises them as 8N1 frames, and honours the AVR's avr_rx_busy flow-control line. Instantiated in the top level in place of the current high-Z tie-off on avr_rx.

---
 rtl/avr_serial_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/avr_serial_tx.sv
// 8N1 UART transmitter towards the AVR: byte FIFO in front of a start/data/stop
// serialiser that only begins a new frame while the synchronised busy line from the AVR is low.
module avr_serial_tx #(
    parameter int CLK_PER_BIT = 100,
    parameter int FIFO_AW     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         data,
    input  logic               new_data,
    output logic               ready,
    input  logic               block,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   count,
    output logic               overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(CLK_PER_BIT - 1);
    localparam logic [FIFO_AW:0] FULL    = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic                 block_m;
    logic                 block_s;

    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic                 push;
    logic                 pop;

    assign ready = (count < FULL);
    assign push  = new_data & ready;
    // The only consumer of the FIFO is the IDLE->START decision.
    assign pop   = (state == IDLE) && (count != '0) && !block_s;
    assign busy  = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            block_m <= 1'b0;
            block_s <= 1'b0;
        end else begin
            block_m <= block;
            block_s <= block_m;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (push && !pop) begin
                count <= count + (FIFO_AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (FIFO_AW + 1)'(1);
            end
            overflow <= new_data & ~ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    tx      <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (clk_cnt == CNT_MAX) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_MAX) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == CNT_MAX) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
